axioma_eeprom_seq: RTL and testbench
====================================

Name: axioma_eeprom_seq

Overview:
- Hardware sequencer and bus arbiter in front of the 1 KB EEPROM controller.
- Accepts single-byte read/write requests from a non-CPU master (ISP/bootloader engine).
- Replays the EEAR/EEDR/EECR register protocol on the controller's 6-bit I/O bus, including the EEMPE→EEPE arming sequence and busy polling.
- Shares that bus with CPU I/O traffic; CPU has passthrough whenever the sequencer is idle.

Parameters:
- TIMEOUT_CYCLES, 16'd8000, max cycles in WAIT_FALL before error (covers 2×3400-cycle erase+program).
- RISE_CYCLES, 4, max cycles in WAIT_RISE for ee_busy to assert after command issue.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_write  in  1  1=write (erase+write, EEPM=00), 0=read
- req_addr  in  10  EEPROM byte address
- req_data  in  8  write data
- req_ready  out  1  request accepted this cycle (valid&&ready handshake)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  8  read data (write: echo of written byte)
- rsp_err  out  1  valid with rsp_valid; timeout/verify failure
- cpu_io_addr  in  6  CPU I/O address
- cpu_io_data_in  in  8  CPU write data
- cpu_io_read  in  1  CPU read strobe
- cpu_io_write  in  1  CPU write strobe
- cpu_io_data_out  out  8  read data to CPU
- cpu_conflict  out  1  pulse: CPU EEPROM-register access dropped
- ee_io_addr  out  6  to controller io_addr
- ee_io_data_in  out  8  to controller io_data_in
- ee_io_read  out  1  to controller io_read
- ee_io_write  out  1  to controller io_write
- ee_io_data_out  in  8  from controller io_data_out
- ee_busy  in  1  controller busy flag (debug_state[4])
- seq_active  out  1  sequencer owns the bus

Behaviour:
- Register map (io_addr): EECR=0x1F, EEDR=0x20, EEARL=0x21, EEARH=0x22. These four are "EEPROM registers".
- Reset: all outputs 0; state IDLE; timers 0.
- Ownership:
  - IDLE: ee_io_* = cpu_io_* combinationally; cpu_io_data_out = ee_io_data_out; seq_active=0.
  - Otherwise: ee_io_* driven by FSM; seq_active=1.
  - CPU access to an EEPROM register while seq_active: dropped; cpu_io_data_out=0x00 for reads; cpu_conflict=1 that cycle.
  - CPU access to other addresses is still forwarded on ee_io_* only when the FSM drives no strobe that cycle; the controller ignores non-EEPROM addresses anyway.
- req_ready=1 only when all hold: IDLE, ee_busy=0, no CPU EEPROM-register strobe this cycle. Accepted addr/data/write are latched.
- FSM, one state per cycle unless noted:
  - IDLE -> SET_AL: write EEARL=addr[7:0].
  - SET_AL -> SET_AH: write EEARH={6'b0,addr[9:8]}.
  - Write path:
    - SET_AH -> SET_DR: write EEDR=data.
    - SET_DR -> ARM: write EECR=0x04 (EEMPE, EEPM=00).
    - ARM -> GO: write EECR=0x06 on the very next cycle.
  - Read path:
    - SET_AH -> GO: write EECR=0x01.
  - GO -> WAIT_RISE: wait for ee_busy=1. Not seen within RISE_CYCLES -> ERR.
  - WAIT_RISE -> WAIT_FALL: wait for ee_busy=0. Timer reaching TIMEOUT_CYCLES -> ERR.
  - WAIT_FALL, read -> FETCH: drive ee_io_read at EEDR and capture ee_io_data_out the same cycle -> DONE.
  - WAIT_FALL, write -> DONE (or VERIFY, see optional feature).
  - DONE: rsp_valid=1, rsp_err=0 -> IDLE.
  - ERR: rsp_valid=1, rsp_err=1, rsp_data=0x00 -> IDLE.
- Only one strobe per cycle on ee_io_*. ee_io_data_in is 0 when not writing.
- Timers: 16-bit, cleared on each state entry, saturating.
- Reset mid-operation: immediate return to IDLE with outputs 0. No response is issued; the EEPROM controller's own state is not repaired.
- req_valid deasserted before acceptance: no effect. Request fields are sampled only at acceptance.

Optional Feature:
- Macro: AXIOMA_EE_SEQ_VERIFY_EN.
- Defined: a write continues from WAIT_FALL into a full read sequence (SET_AL, SET_AH, GO with 0x01, WAIT_RISE, WAIT_FALL, FETCH). It then reaches DONE only if the fetched byte equals the latched data; otherwise ERR. rsp_data carries the fetched byte.
- Undefined: no VERIFY states; a write completes at DONE after WAIT_FALL.

Test Plan:
- Write addr 0x2A5, data 0x3C, model busy for 6800 cycles -> ee_io writes in order: 0x21:0xA5, 0x22:0x02, 0x20:0x3C, 0x1F:0x04, 0x1F:0x06 on consecutive cycles. Then rsp_valid with rsp_err=0.
- Read addr 0x003, model returns 0x5A -> 0x1F:0x01 issued; after busy falls, EEDR read; rsp_data=0x5A, rsp_err=0.
- CPU writes 0x21 during sequencer WAIT_FALL -> write not forwarded, cpu_conflict=1 one cycle; CPU read of 0x1F returns 0x00.
- ee_busy held 1 beyond TIMEOUT_CYCLES -> rsp_valid with rsp_err=1, rsp_data=0x00. ee_busy never rising -> ERR after RISE_CYCLES.
- req_valid while ee_busy=1 (CPU-initiated op) -> req_ready=0 until busy drops; then accepted. Reset asserted in ARM -> all outputs 0 asynchronously, no rsp_valid.
- With AXIOMA_EE_SEQ_VERIFY_EN, model corrupts stored byte to 0x38 -> write of 0x3C gives rsp_err=1, rsp_data=0x38.

Source files
------------

// File: rtl/axioma_eeprom_seq.sv
// axioma_eeprom_seq: sequencer and bus arbiter in front of the 1 KB EEPROM
// controller. Single-byte requests from a non-CPU master are replayed as
// EEAR/EEDR/EECR register writes on the controller's 6-bit I/O bus, with
// the EEMPE->EEPE arming pair and busy polling. The CPU owns the bus
// whenever the sequencer is idle.
// Optional feature: define AXIOMA_EE_SEQ_VERIFY_EN to read back every
// written byte and flag an error if it does not match.
module axioma_eeprom_seq #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8000,
    parameter int          RISE_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_write,
    input  logic [9:0] req_addr,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    input  logic [5:0] cpu_io_addr,
    input  logic [7:0] cpu_io_data_in,
    input  logic       cpu_io_read,
    input  logic       cpu_io_write,
    output logic [7:0] cpu_io_data_out,
    output logic       cpu_conflict,
    output logic [5:0] ee_io_addr,
    output logic [7:0] ee_io_data_in,
    output logic       ee_io_read,
    output logic       ee_io_write,
    input  logic [7:0] ee_io_data_out,
    input  logic       ee_busy,
    output logic       seq_active
);

    localparam logic [5:0]  ADDR_EECR  = 6'h1F;
    localparam logic [5:0]  ADDR_EEDR  = 6'h20;
    localparam logic [5:0]  ADDR_EEARL = 6'h21;
    localparam logic [5:0]  ADDR_EEARH = 6'h22;
    localparam logic [15:0] RISE_LIMIT = 16'(RISE_CYCLES - 1);
    localparam logic [15:0] FALL_LIMIT = TIMEOUT_CYCLES - 16'd1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET_AL,
        S_SET_AH,
        S_SET_DR,
        S_ARM,
        S_GO,
        S_WAIT_RISE,
        S_WAIT_FALL,
        S_FETCH,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [9:0]  lat_addr;
    logic [7:0]  lat_data;
    logic        lat_write;
    logic [7:0]  rsp_byte;
    logic [15:0] timer;

    logic        cpu_is_ee;
    logic        cpu_strobe;
    logic        accept;
    logic        issue_write;
    logic        fsm_rd;
    logic        fsm_wr;
    logic [5:0]  fsm_addr;
    logic [7:0]  fsm_wdata;

    assign cpu_is_ee  = (cpu_io_addr >= ADDR_EECR) && (cpu_io_addr <= ADDR_EEARH);
    assign cpu_strobe = cpu_io_read || cpu_io_write;
    assign req_ready  = !reset && (state == S_IDLE) && !ee_busy && !(cpu_strobe && cpu_is_ee);
    assign accept     = req_valid && req_ready;

`ifdef AXIOMA_EE_SEQ_VERIFY_EN
    logic verify_phase;

    // Tracks whether the current write has moved on to its read-back pass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            verify_phase <= 1'b0;
        end else if (accept) begin
            verify_phase <= 1'b0;
        end else if (state == S_WAIT_FALL && state_next == S_SET_AL) begin
            verify_phase <= 1'b1;
        end
    end

    assign issue_write = lat_write && !verify_phase;
`else
    assign issue_write = lat_write;
`endif

    // State register, request latches, response byte and per-state timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_write <= 1'b0;
            rsp_byte  <= '0;
            timer     <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                timer <= '0;
            end else if (timer != 16'hFFFF) begin
                timer <= timer + 16'd1;
            end
            if (accept) begin
                lat_addr  <= req_addr;
                lat_data  <= req_data;
                lat_write <= req_write;
                rsp_byte  <= req_data;
            end else if (state == S_FETCH) begin
                rsp_byte <= ee_io_data_out;
            end else if (state_next == S_ERR) begin
                rsp_byte <= '0;
            end
        end
    end

    // Next-state logic and the register access each state replays
    always_comb begin
        state_next = state;
        fsm_rd     = 1'b0;
        fsm_wr     = 1'b0;
        fsm_addr   = '0;
        fsm_wdata  = '0;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_SET_AL;
            end
            S_SET_AL: begin
                fsm_wr     = 1'b1;
                fsm_addr   = ADDR_EEARL;
                fsm_wdata  = lat_addr[7:0];
                state_next = S_SET_AH;
            end
            S_SET_AH: begin
                fsm_wr     = 1'b1;
                fsm_addr   = ADDR_EEARH;
                fsm_wdata  = {6'b0, lat_addr[9:8]};
                state_next = issue_write ? S_SET_DR : S_GO;
            end
            S_SET_DR: begin
                fsm_wr     = 1'b1;
                fsm_addr   = ADDR_EEDR;
                fsm_wdata  = lat_data;
                state_next = S_ARM;
            end
            S_ARM: begin
                fsm_wr     = 1'b1;
                fsm_addr   = ADDR_EECR;
                fsm_wdata  = 8'h04;
                state_next = S_GO;
            end
            S_GO: begin
                fsm_wr     = 1'b1;
                fsm_addr   = ADDR_EECR;
                fsm_wdata  = issue_write ? 8'h06 : 8'h01;
                state_next = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (ee_busy) begin
                    state_next = S_WAIT_FALL;
                end else if (timer >= RISE_LIMIT) begin
                    state_next = S_ERR;
                end
            end
            S_WAIT_FALL: begin
                if (!ee_busy) begin
`ifdef AXIOMA_EE_SEQ_VERIFY_EN
                    state_next = issue_write ? S_SET_AL : S_FETCH;
`else
                    state_next = lat_write ? S_DONE : S_FETCH;
`endif
                end else if (timer >= FALL_LIMIT) begin
                    state_next = S_ERR;
                end
            end
            S_FETCH: begin
                fsm_rd   = 1'b1;
                fsm_addr = ADDR_EEDR;
`ifdef AXIOMA_EE_SEQ_VERIFY_EN
                state_next = (lat_write && ee_io_data_out != lat_data) ? S_ERR : S_DONE;
`else
                state_next = S_DONE;
`endif
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus ownership: CPU passthrough while idle, sequencer otherwise
    always_comb begin
        ee_io_addr      = '0;
        ee_io_data_in   = '0;
        ee_io_read      = 1'b0;
        ee_io_write     = 1'b0;
        cpu_io_data_out = '0;
        cpu_conflict    = 1'b0;
        seq_active      = 1'b0;
        if (reset) begin
            seq_active = 1'b0;
        end else if (state == S_IDLE) begin
            ee_io_addr      = cpu_io_addr;
            ee_io_data_in   = cpu_io_write ? cpu_io_data_in : 8'h00;
            ee_io_read      = cpu_io_read;
            ee_io_write     = cpu_io_write;
            cpu_io_data_out = ee_io_data_out;
        end else begin
            seq_active   = 1'b1;
            cpu_conflict = cpu_strobe && cpu_is_ee;
            if (fsm_rd || fsm_wr) begin
                ee_io_addr    = fsm_addr;
                ee_io_data_in = fsm_wdata;
                ee_io_read    = fsm_rd;
                ee_io_write   = fsm_wr;
            end else if (cpu_strobe && !cpu_is_ee) begin
                ee_io_addr      = cpu_io_addr;
                ee_io_data_in   = cpu_io_write ? cpu_io_data_in : 8'h00;
                ee_io_read      = cpu_io_read;
                ee_io_write     = cpu_io_write;
                cpu_io_data_out = cpu_io_read ? ee_io_data_out : 8'h00;
            end
        end
    end

    // Completion pulse for the master
    always_comb begin
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        if (!reset && state == S_DONE) begin
            rsp_valid = 1'b1;
            rsp_data  = rsp_byte;
        end else if (!reset && state == S_ERR) begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
            rsp_data  = rsp_byte;
        end
    end

endmodule

// File: tb/tb_axioma_eeprom_seq.sv
// Testbench for axioma_eeprom_seq: a behavioural EEPROM controller model
// answers the register protocol, and a byte-array reference of EEPROM
// contents supplies expected read data. Compile with
// AXIOMA_EE_SEQ_VERIFY_EN defined to also exercise the read-back check.
module tb_axioma_eeprom_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [9:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [5:0] cpu_io_addr = '0;
    logic [7:0] cpu_io_data_in = '0;
    logic       cpu_io_read = 1'b0;
    logic       cpu_io_write = 1'b0;
    logic [7:0] cpu_io_data_out;
    logic       cpu_conflict;
    logic [5:0] ee_io_addr;
    logic [7:0] ee_io_data_in;
    logic       ee_io_read;
    logic       ee_io_write;
    logic [7:0] ee_io_data_out;
    logic       ee_busy;
    logic       seq_active;

    int n_checks = 0;
    int n_fail   = 0;

    axioma_eeprom_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cpu_io_addr(cpu_io_addr), .cpu_io_data_in(cpu_io_data_in),
        .cpu_io_read(cpu_io_read), .cpu_io_write(cpu_io_write),
        .cpu_io_data_out(cpu_io_data_out), .cpu_conflict(cpu_conflict),
        .ee_io_addr(ee_io_addr), .ee_io_data_in(ee_io_data_in),
        .ee_io_read(ee_io_read), .ee_io_write(ee_io_write),
        .ee_io_data_out(ee_io_data_out), .ee_busy(ee_busy),
        .seq_active(seq_active)
    );

    always #5 clk = ~clk;

    // ---------------- EEPROM controller model ----------------
    logic [7:0] mem [1024];
    logic [9:0] m_ear = '0;
    logic [7:0] m_edr = '0;
    logic       m_armed = 1'b0;
    logic       m_op_write = 1'b0;
    int         m_wait = 0;
    int         m_busy_left = 0;
    bit         m_init_done = 1'b0;
    int         busy_len = 20;
    int         rise_delay = 0;
    bit         never_rise = 1'b0;
    bit         hold_busy = 1'b0;
    bit         corrupt_en = 1'b0;
    logic [7:0] corrupt_val = 8'h00;

    function automatic logic [7:0] init_val(input int i);
        if (i == 3) return 8'h5A;
        return 8'((i * 29 + 11) % 256);
    endfunction

    assign ee_busy        = (m_busy_left != 0) || hold_busy;
    assign ee_io_data_out = (ee_io_read && ee_io_addr == 6'h20) ? m_edr : 8'h00;

    // Controller behaviour: register writes, arming window, busy period
    always @(posedge clk) begin
        if (!m_init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            m_init_done <= 1'b1;
        end
        if (m_wait > 0) begin
            if (m_wait == 1) m_busy_left <= busy_len;
            m_wait <= m_wait - 1;
        end
        if (m_busy_left > 0) begin
            m_busy_left <= m_busy_left - 1;
            if (m_busy_left == 1) begin
                if (m_op_write) mem[m_ear] <= corrupt_en ? corrupt_val : m_edr;
                else            m_edr <= mem[m_ear];
            end
        end
        m_armed <= ee_io_write && ee_io_addr == 6'h1F && ee_io_data_in == 8'h04;
        if (ee_io_write) begin
            case (ee_io_addr)
                6'h21: m_ear[7:0] <= ee_io_data_in;
                6'h22: m_ear[9:8] <= ee_io_data_in[1:0];
                6'h20: m_edr <= ee_io_data_in;
                6'h1F: begin
                    if (ee_io_data_in == 8'h01 || (ee_io_data_in == 8'h06 && m_armed)) begin
                        m_op_write <= (ee_io_data_in == 8'h06);
                        if (!never_rise) begin
                            if (rise_delay == 0) m_busy_left <= busy_len;
                            else                 m_wait <= rise_delay;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct {
        int         cyc;
        logic [5:0] a;
        logic [7:0] d;
    } wr_entry_t;

    wr_entry_t wr_log[$];
    int cyc_count  = 0;
    int eedr_reads = 0;
    int rsp_count  = 0;

    // Records every bus write, EEDR reads and response pulses
    always @(posedge clk) begin
        if (ee_io_write) wr_log.push_back('{cyc_count, ee_io_addr, ee_io_data_in});
        if (ee_io_read && ee_io_addr == 6'h20) eedr_reads++;
        if (rsp_valid) rsp_count++;
        cyc_count++;
    end

    // ---------------- reference and helpers ----------------
    logic [7:0] ref_mem [1024];
    logic [5:0] exp_a [5] = '{6'h21, 6'h22, 6'h20, 6'h1F, 6'h1F};
    logic [7:0] exp_d [5] = '{8'hA5, 8'h02, 8'h3C, 8'h04, 8'h06};
    int         base;
    int         rd_base;
    int         rsp_before;
    int         n_wait;
    logic       r_wr;
    logic [9:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_exp;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic start_request(input logic wr, input logic [9:0] a, input logic [7:0] d, input string tag);
        int n = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        #1;
        while (!req_ready && n < 12000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_output({tag, "_accept"}, req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 10'($urandom);
        req_data  = 8'($urandom);
    endtask

    task automatic wait_response(input logic exp_err, input logic [7:0] exp_data, input string tag);
        int n = 0;
        while (!rsp_valid && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_rsp_valid"}, rsp_valid, 1);
        check_output({tag, "_rsp_err"}, rsp_err, exp_err);
        check_output({tag, "_rsp_data"}, rsp_data, exp_data);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic wr, input logic [9:0] a, input logic [7:0] d,
                                  input logic exp_err, input logic [7:0] exp_data, input string tag);
        start_request(wr, a, d, tag);
        wait_response(exp_err, exp_data, tag);
    endtask

    // Hard stop if something hangs beyond every per-step bound
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed and randomized sequence
    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

        // Reset state
        @(negedge clk);
        check_output("reset_req_ready", req_ready, 0);
        check_output("reset_rsp_valid", rsp_valid, 0);
        check_output("reset_seq_active", seq_active, 0);
        check_output("reset_ee_write", ee_io_write, 0);
        check_output("reset_ee_read", ee_io_read, 0);
        check_output("reset_ee_addr", ee_io_addr, 0);
        check_output("reset_conflict", cpu_conflict, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Idle passthrough and CPU EEPROM strobe blocking acceptance
        cpu_io_read = 1'b1;
        cpu_io_addr = 6'h20;
        #1;
        check_output("idle_pass_read", ee_io_read, 1);
        check_output("idle_pass_addr", ee_io_addr, 6'h20);
        check_output("idle_ready_blocked", req_ready, 0);
        check_output("idle_no_conflict", cpu_conflict, 0);
        @(negedge clk);
        cpu_io_read = 1'b0;
        cpu_io_addr = 6'h00;
        #1;
        check_output("idle_ready", req_ready, 1);

        // Write 0x3C to 0x2A5 with a long program time
        @(negedge clk);
        busy_len = 6800;
        rise_delay = 0;
        base = wr_log.size();
        apply_stimulus(1'b1, 10'h2A5, 8'h3C, 1'b0, 8'h3C, "wr_2a5");
        ref_mem[10'h2A5] = 8'h3C;
        check_output("wr_seq_count", (wr_log.size() - base) >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("wr_seq_addr%0d", i), wr_log[base + i].a, exp_a[i]);
            check_output($sformatf("wr_seq_data%0d", i), wr_log[base + i].d, exp_d[i]);
            check_output($sformatf("wr_seq_cyc%0d", i), wr_log[base + i].cyc - wr_log[base].cyc, i);
        end

        // Read 0x003 (holds 0x5A)
        busy_len = 20;
        base = wr_log.size();
        rd_base = eedr_reads;
        apply_stimulus(1'b0, 10'h003, 8'h00, 1'b0, 8'h5A, "rd_003");
        check_output("rd_seq_count", wr_log.size() - base, 3);
        check_output("rd_seq_al", {wr_log[base].a, wr_log[base].d}, {6'h21, 8'h03});
        check_output("rd_seq_ah", {wr_log[base + 1].a, wr_log[base + 1].d}, {6'h22, 8'h00});
        check_output("rd_seq_go", {wr_log[base + 2].a, wr_log[base + 2].d}, {6'h1F, 8'h01});
        check_output("rd_eedr_reads", eedr_reads - rd_base, 1);

        // CPU traffic while the sequencer waits for busy to fall
        busy_len = 50;
        start_request(1'b1, 10'h155, 8'hC3, "conf_wr");
        n_wait = 0;
        while (!(ee_busy && seq_active) && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        @(negedge clk);
        cpu_io_write = 1'b1;
        cpu_io_addr = 6'h21;
        cpu_io_data_in = 8'h77;
        #1;
        check_output("conf_wr_flag", cpu_conflict, 1);
        check_output("conf_wr_blocked", ee_io_write, 0);
        @(negedge clk);
        cpu_io_write = 1'b0;
        cpu_io_read = 1'b1;
        cpu_io_addr = 6'h1F;
        #1;
        check_output("conf_rd_flag", cpu_conflict, 1);
        check_output("conf_rd_data", cpu_io_data_out, 8'h00);
        check_output("conf_rd_blocked", ee_io_read, 0);
        @(negedge clk);
        cpu_io_read = 1'b0;
        cpu_io_write = 1'b1;
        cpu_io_addr = 6'h10;
        cpu_io_data_in = 8'h99;
        #1;
        check_output("fwd_wr_strobe", ee_io_write, 1);
        check_output("fwd_wr_addr", ee_io_addr, 6'h10);
        check_output("fwd_no_conflict", cpu_conflict, 0);
        @(negedge clk);
        cpu_io_write = 1'b0;
        cpu_io_addr = 6'h00;
        cpu_io_data_in = 8'h00;
        #1;
        check_output("conf_cleared", cpu_conflict, 0);
        wait_response(1'b0, 8'hC3, "conf_wr");
        ref_mem[10'h155] = 8'hC3;
        apply_stimulus(1'b0, 10'h155, 8'h00, 1'b0, ref_mem[10'h155], "conf_rdback");

        // Busy never falls: timeout error
        busy_len = 8200;
        apply_stimulus(1'b0, 10'h0AA, 8'h00, 1'b1, 8'h00, "timeout");
        busy_len = 20;

        // Busy never rises: rise error
        never_rise = 1'b1;
        apply_stimulus(1'b0, 10'h0AB, 8'h00, 1'b1, 8'h00, "norise");
        never_rise = 1'b0;

        // Request held off while the controller is busy
        @(negedge clk);
        hold_busy = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 10'h003;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_output($sformatf("busy_block_ready%0d", i), req_ready, 0);
            @(negedge clk);
        end
        check_output("busy_block_idle", seq_active, 0);
        hold_busy = 1'b0;
        #1;
        check_output("busy_release_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_output("busy_accept_active", seq_active, 1);
        wait_response(1'b0, ref_mem[10'h003], "busy_rd");

        // Reset asserted while arming
        rsp_before = rsp_count;
        start_request(1'b1, 10'h0F0, 8'hE1, "rst_arm");
        n_wait = 0;
        while (!(ee_io_write && ee_io_addr == 6'h1F && ee_io_data_in == 8'h04) && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        check_output("rst_arm_reached", ee_io_data_in, 8'h04);
        #1;
        reset = 1'b1;
        #1;
        check_output("rst_ee_write", ee_io_write, 0);
        check_output("rst_ee_addr", ee_io_addr, 0);
        check_output("rst_ee_data", ee_io_data_in, 0);
        check_output("rst_seq_active", seq_active, 0);
        check_output("rst_rsp_valid", rsp_valid, 0);
        check_output("rst_req_ready", req_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_output("rst_no_rsp", rsp_count - rsp_before, 0);
        check_output("rst_idle", seq_active, 0);

        // Randomized reads and writes against the reference contents
        for (int k = 0; k < 20; k++) begin
            busy_len = $urandom_range(1, 40);
            rise_delay = $urandom_range(0, 2);
            r_wr = 1'($urandom);
            r_addr = 10'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) r_addr = r_addr | 10'h3F8;
            r_data = 8'($urandom);
            if (r_wr) begin
                r_exp = r_data;
                ref_mem[r_addr] = r_data;
            end else begin
                r_exp = ref_mem[r_addr];
            end
            apply_stimulus(r_wr, r_addr, r_data, 1'b0, r_exp, $sformatf("rand%0d", k));
        end
        rise_delay = 0;

`ifdef AXIOMA_EE_SEQ_VERIFY_EN
        // Read-back mismatch after a corrupted program
        busy_len = 20;
        corrupt_en = 1'b1;
        corrupt_val = 8'h38;
        apply_stimulus(1'b1, 10'h2A5, 8'h3C, 1'b1, 8'h38, "verify_corrupt");
        corrupt_en = 1'b0;
        ref_mem[10'h2A5] = 8'h38;
        apply_stimulus(1'b0, 10'h2A5, 8'h00, 1'b0, ref_mem[10'h2A5], "verify_rdback");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
